// File: rtl/control_unit_checker_if.sv
// control_unit_checker_if: table-load, run-control, control-unit and result signals of the checker.
interface control_unit_checker_if #(
    parameter int ADDR_W = 6,
    parameter int INS_W  = 32,
    parameter int CW_W   = 25
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [INS_W-1:0]  load_ins;
    logic [CW_W-1:0]   load_exp;
    logic [CW_W-1:0]   load_mask;
    logic              start;
    logic [ADDR_W:0]   count;
    logic              stop_on_fail;
    logic [INS_W-1:0]  INSTRUCTION;
    logic [CW_W-1:0]   ctrl_word;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       fail_count;
    logic              first_fail_valid;
    logic [ADDR_W-1:0] first_fail_idx;
    logic [CW_W-1:0]   first_fail_word;
    modport master (
        output load_en, load_addr, load_ins, load_exp, load_mask, start, count, stop_on_fail, ctrl_word,
        input  INSTRUCTION, busy, done, pass, fail_count, first_fail_valid, first_fail_idx, first_fail_word
    );
    modport slave (
        input  load_en, load_addr, load_ins, load_exp, load_mask, start, count, stop_on_fail, ctrl_word,
        output INSTRUCTION, busy, done, pass, fail_count, first_fail_valid, first_fail_idx, first_fail_word
    );
endinterface

// File: rtl/control_unit_checker.sv
// control_unit_checker: on-chip sequencer driving a table of instructions into the control unit
// and comparing each returned control word against a masked expectation.
module control_unit_checker #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int INS_W  = 32,
    parameter int CW_W   = 25,
    parameter int SETTLE = 4,
    parameter logic [INS_W-1:0] IDLE_INS = 32'h00000013
) (
    input logic CLK,
    input logic RESET,
    control_unit_checker_if.slave bus
);
    localparam int SW = $clog2(SETTLE) + 1;
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
    state_t state, nxt;
    logic [INS_W-1:0]  ins_mem  [DEPTH];
    logic [CW_W-1:0]   exp_mem  [DEPTH];
    logic [CW_W-1:0]   mask_mem [DEPTH];
    logic [ADDR_W-1:0] idx, last;
    logic [SW-1:0]     settle;
    logic              sof;
    logic              accept, mismatch, finish, busy_d, done_d;
    logic [ADDR_W:0]   clamped;
    logic [15:0]       fail_nxt;
    logic [INS_W-1:0]  ins_d;
    // Table contents deliberately survive reset so a run can be repeated without reloading.
    always_ff @(posedge CLK)
        if (bus.load_en && !bus.busy && {1'b0, bus.load_addr} < (ADDR_W+1)'(DEPTH)) begin
            ins_mem[bus.load_addr]  <= bus.load_ins;
            exp_mem[bus.load_addr]  <= bus.load_exp;
            mask_mem[bus.load_addr] <= bus.load_mask;
        end
    assign accept   = (state == IDLE || state == DONE) && bus.start;
    assign clamped  = bus.count > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : bus.count;
    assign mismatch = |((bus.ctrl_word ^ exp_mem[idx]) & mask_mem[idx]);
    assign finish   = idx == last || (mismatch && sof);
    assign fail_nxt = (mismatch && bus.fail_count != 16'hFFFF) ? bus.fail_count + 16'd1 : bus.fail_count;
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DONE: if (bus.start) nxt = bus.count == '0 ? DONE : DRIVE;
            DRIVE:      nxt = WAIT;
            WAIT:       nxt = settle == '0 ? CHECK : WAIT;
            CHECK:      nxt = finish ? DONE : DRIVE;
            default:    nxt = IDLE;
        endcase
    end
    always_comb begin
        busy_d = nxt == DRIVE || nxt == WAIT || nxt == CHECK;
        done_d = nxt == DONE;
        ins_d  = state == DRIVE ? ins_mem[idx] : (nxt == DONE || nxt == IDLE) ? IDLE_INS : bus.INSTRUCTION;
    end
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            idx                  <= '0;
            last                 <= '0;
            sof                  <= 1'b0;
            settle               <= '0;
            bus.INSTRUCTION      <= IDLE_INS;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.pass             <= 1'b0;
            bus.fail_count       <= '0;
            bus.first_fail_valid <= 1'b0;
            bus.first_fail_idx   <= '0;
            bus.first_fail_word  <= '0;
        end else begin
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            bus.INSTRUCTION <= ins_d;
            if (accept) begin
                idx                  <= '0;
                last                 <= ADDR_W'(clamped - 1'b1);
                sof                  <= bus.stop_on_fail;
                bus.pass             <= bus.count == '0;
                bus.fail_count       <= '0;
                bus.first_fail_valid <= 1'b0;
                bus.first_fail_idx   <= '0;
                bus.first_fail_word  <= '0;
            end
            if (state == DRIVE) settle <= SW'(SETTLE - 1);
            if (state == WAIT && settle != '0) settle <= settle - 1'b1;
            if (state == CHECK) begin
                bus.fail_count <= fail_nxt;
                if (mismatch && !bus.first_fail_valid) begin
                    bus.first_fail_valid <= 1'b1;
                    bus.first_fail_idx   <= idx;
                    bus.first_fail_word  <= bus.ctrl_word;
                end
                if (finish) bus.pass <= fail_nxt == 16'd0;
                else idx <= idx + 1'b1;
            end
        end
endmodule

// File: tb/tb_control_unit_checker.sv
// tb_control_unit_checker: directed bench with a stub control unit answering three known instructions.
module tb_control_unit_checker;
    localparam int ADDR_W = 6, INS_W = 32, CW_W = 25;
    localparam logic [31:0] ADD  = 32'h00B50533, SUB = 32'h40B50533, ADDI = 32'h00150513, NOP = 32'h00000013;
    localparam logic [24:0] W_ADD = 25'h0080000, W_SUB = 25'h0180000, W_ADDI = 25'h0080014;
    localparam logic [24:0] ONES = 25'h1FFFFFF, BIT20 = 25'h0100000;
    logic CLK = 1'b0, RESET = 1'b0;
    int errors = 0, checks = 0, lat;
    control_unit_checker_if #(.ADDR_W(ADDR_W), .INS_W(INS_W), .CW_W(CW_W)) bus ();
    control_unit_checker #(.DEPTH(64), .ADDR_W(ADDR_W), .INS_W(INS_W), .CW_W(CW_W), .SETTLE(4),
                           .IDLE_INS(NOP)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;
    assign bus.ctrl_word = bus.INSTRUCTION == ADD ? W_ADD : bus.INSTRUCTION == SUB ? W_SUB :
                           bus.INSTRUCTION == ADDI ? W_ADDI : 25'h0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic load(input int a, input logic [31:0] ins, input logic [24:0] e, input logic [24:0] m);
        bus.load_en = 1'b1; bus.load_addr = 6'(a); bus.load_ins = ins; bus.load_exp = e; bus.load_mask = m;
        @(posedge CLK); #1;
        bus.load_en = 1'b0;
    endtask
    task automatic wait_done(inout int l);
        while (!bus.done && l < 1000) begin
            @(posedge CLK); #1;
            l++;
        end
    endtask
    task automatic run(input logic [6:0] cnt, input logic s, output int l);
        bus.start = 1'b1; bus.count = cnt; bus.stop_on_fail = s;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        l = 0;
        wait_done(l);
    endtask
    task automatic expect_pass_run(input string tag);
        run(7'd3, 1'b0, lat);
        chk({tag, "_lat"}, lat, 18);
        chk({tag, "_pass"}, bus.pass, 1);
        chk({tag, "_fails"}, bus.fail_count, 0);
        chk({tag, "_ffv"}, bus.first_fail_valid, 0);
    endtask
    initial begin
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_ins = '0; bus.load_exp = '0; bus.load_mask = '0;
        bus.start = 1'b0; bus.count = '0; bus.stop_on_fail = 1'b0;
        #12;
        chk("rst_ins", bus.INSTRUCTION, NOP);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        load(0, ADD, W_ADD, ONES);
        load(1, SUB, W_SUB, ONES);
        load(2, ADDI, W_ADDI, ONES);
        for (int i = 3; i < 64; i++) load(i, ADD, W_ADD, ONES);
        // all-matching run with mid-run drive checks
        bus.start = 1'b1; bus.count = 7'd3; bus.stop_on_fail = 1'b0;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        chk("s1_busy", bus.busy, 1);
        chk("s1_done_clr", bus.done, 0);
        @(posedge CLK); #1;
        chk("s1_ins0", bus.INSTRUCTION, ADD);
        repeat (6) @(posedge CLK);
        #1;
        chk("s1_ins1", bus.INSTRUCTION, SUB);
        lat = 7;
        wait_done(lat);
        chk("s1_lat", lat, 18);
        chk("s1_pass", bus.pass, 1);
        chk("s1_fails", bus.fail_count, 0);
        chk("s1_ffv", bus.first_fail_valid, 0);
        chk("s1_busy_end", bus.busy, 0);
        chk("s1_ins_idle", bus.INSTRUCTION, NOP);
        // entry 1 expects alu bit 0 flipped
        load(1, SUB, W_SUB ^ BIT20, ONES);
        run(7'd3, 1'b0, lat);
        chk("s2_lat", lat, 18);
        chk("s2_fails", bus.fail_count, 1);
        chk("s2_pass", bus.pass, 0);
        chk("s2_ffv", bus.first_fail_valid, 1);
        chk("s2_ffi", bus.first_fail_idx, 1);
        chk("s2_ffw", bus.first_fail_word, W_SUB);
        run(7'd3, 1'b1, lat);
        chk("s3_lat", lat, 12);
        chk("s3_fails", bus.fail_count, 1);
        chk("s3_ffi", bus.first_fail_idx, 1);
        // differing bit masked off
        load(1, SUB, W_SUB ^ BIT20, ONES ^ BIT20);
        run(7'd3, 1'b0, lat);
        chk("s4_lat", lat, 18);
        chk("s4_pass", bus.pass, 1);
        run(7'd0, 1'b0, lat);
        chk("s4_zero_lat", lat, 0);
        chk("s4_zero_pass", bus.pass, 1);
        chk("s4_zero_fails", bus.fail_count, 0);
        run(7'd70, 1'b0, lat);
        chk("s4_clamp_lat", lat, 64 * 6);
        chk("s4_clamp_pass", bus.pass, 1);
        // abort by reset, then rerun without reload
        load(1, SUB, W_SUB, ONES);
        bus.start = 1'b1; bus.count = 7'd3; bus.stop_on_fail = 1'b0;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        chk("s5_ins", bus.INSTRUCTION, NOP);
        chk("s5_busy", bus.busy, 0);
        chk("s5_done", bus.done, 0);
        chk("s5_pass", bus.pass, 0);
        chk("s5_fails", bus.fail_count, 0);
        chk("s5_ffv", bus.first_fail_valid, 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        expect_pass_run("s5_rerun");
        // load and start while busy must both be ignored
        bus.start = 1'b1; bus.count = 7'd3; bus.stop_on_fail = 1'b0;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 1000) begin
            @(posedge CLK); #1;
            lat++;
            bus.load_en = lat == 3;
            bus.load_addr = 6'd1; bus.load_ins = ADD; bus.load_exp = 25'h0; bus.load_mask = ONES;
            bus.start = lat == 6;
            if (lat == 6) bus.count = 7'd1;
        end
        bus.load_en = 1'b0; bus.start = 1'b0;
        chk("s6_lat", lat, 18);
        chk("s6_pass", bus.pass, 1);
        expect_pass_run("s6_next");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
